// File: rtl/scene_renderer.sv
// Two-stage pixel renderer: player/car sprites over a tiled background, with per-frame
// player/car collision detection when SCENE_COLLISION_EN is defined (default build: collision outputs tied 0).
module scene_renderer #(
  parameter int NUM_CARS     = 4,
  parameter int COLOR_BITS   = 1,
  parameter int H_DISPLAY    = 640,
  parameter int V_DISPLAY    = 480,
  parameter int PLAYER_W     = 16,
  parameter int PLAYER_H     = 16,
  parameter int CAR_W        = 32,
  parameter int CAR_H        = 16,
  parameter int TILE_X0      = 10,
  parameter int TILE_Y0      = 320,
  parameter int TILE_PITCH_X = 35,
  parameter int TILE_PITCH_Y = 32,
  parameter int TILE_W       = 30,
  parameter int TILE_H       = 28,
  parameter int TILE_COLS    = 18,
  parameter int TILE_ROWS    = 5
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [9:0]               h_count,
  input  logic [9:0]               v_count,
  input  logic [9:0]               player_x,
  input  logic [9:0]               player_y,
  input  logic [10*NUM_CARS-1:0]   car_x,
  input  logic [10*NUM_CARS-1:0]   car_y,
  output logic [COLOR_BITS-1:0]    VGA_R,
  output logic [COLOR_BITS-1:0]    VGA_G,
  output logic [COLOR_BITS-1:0]    VGA_B,
  output logic                     collision,
  output logic [7:0]               collision_count
);

  localparam int CPW = $clog2(TILE_PITCH_X + 1);
  localparam int CIW = $clog2(TILE_COLS + 1);
  localparam int RPW = $clog2(TILE_PITCH_Y + 1);
  localparam int RIW = $clog2(TILE_ROWS + 1);

  localparam logic [CPW-1:0] COL_LAST = CPW'(TILE_PITCH_X - 1);
  localparam logic [CPW-1:0] COL_WID  = CPW'(TILE_W);
  localparam logic [CIW-1:0] COL_END  = CIW'(TILE_COLS);
  localparam logic [RPW-1:0] ROW_LAST = RPW'(TILE_PITCH_Y - 1);
  localparam logic [RPW-1:0] ROW_HGT  = RPW'(TILE_H);
  localparam logic [RIW-1:0] ROW_END  = RIW'(TILE_ROWS);

  localparam logic [COLOR_BITS-1:0] FULL = '1;
  localparam logic [COLOR_BITS-1:0] OFF  = '0;

  // Sprite bounds are compared 11 bits wide so x+W never wraps past 1023.
  logic [10:0] h_w, v_w, pl_x, pl_y;
  assign h_w  = {1'b0, h_count};
  assign v_w  = {1'b0, v_count};
  assign pl_x = {1'b0, player_x};
  assign pl_y = {1'b0, player_y};

  logic player_hit_d, car_hit_d, tile_hit_d, active_d;
  logic player_hit_q, car_hit_q, tile_hit_q, active_q;

  assign player_hit_d = (pl_x <= h_w) && (h_w < pl_x + 11'(PLAYER_W)) &&
                        (pl_y <= v_w) && (v_w < pl_y + 11'(PLAYER_H));
  assign active_d     = (h_count < 10'(H_DISPLAY)) && (v_count < 10'(V_DISPLAY));

  always_comb begin
    car_hit_d = 1'b0;
    for (int i = 0; i < NUM_CARS; i++) begin
      if (({1'b0, car_x[10*i +: 10]} <= h_w) && (h_w < {1'b0, car_x[10*i +: 10]} + 11'(CAR_W)) &&
          ({1'b0, car_y[10*i +: 10]} <= v_w) && (v_w < {1'b0, car_y[10*i +: 10]} + 11'(CAR_H)))
        car_hit_d = 1'b1;
    end
  end

  // Tile grid: phase/index counters replace divide and modulo; valid bits stay low until the first load.
  logic [CPW-1:0] col_phase_d, col_phase_q;
  logic [CIW-1:0] col_idx_d, col_idx_q;
  logic           col_vld_d, col_vld_q;
  logic [RPW-1:0] row_phase_d, row_phase_q;
  logic [RIW-1:0] row_idx_d, row_idx_q;
  logic           row_vld_d, row_vld_q;

  always_comb begin
    col_phase_d = col_phase_q;
    col_idx_d   = col_idx_q;
    col_vld_d   = col_vld_q;
    if (h_count == 10'(TILE_X0)) begin
      col_phase_d = '0;
      col_idx_d   = '0;
      col_vld_d   = 1'b1;
    end else if (col_vld_q) begin
      if (col_phase_q == COL_LAST) begin
        col_phase_d = '0;
        if (col_idx_q != COL_END) col_idx_d = col_idx_q + 1'b1;
      end else begin
        col_phase_d = col_phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    row_phase_d = row_phase_q;
    row_idx_d   = row_idx_q;
    row_vld_d   = row_vld_q;
    if (h_count == 10'd0) begin
      if (v_count == 10'(TILE_Y0)) begin
        row_phase_d = '0;
        row_idx_d   = '0;
        row_vld_d   = 1'b1;
      end else if (row_vld_q) begin
        if (row_phase_q == ROW_LAST) begin
          row_phase_d = '0;
          if (row_idx_q != ROW_END) row_idx_d = row_idx_q + 1'b1;
        end else begin
          row_phase_d = row_phase_q + 1'b1;
        end
      end
    end
  end

  assign tile_hit_d = col_vld_d && (col_phase_d < COL_WID) && (col_idx_d < COL_END) &&
                      row_vld_d && (row_phase_d < ROW_HGT) && (row_idx_d < ROW_END);

  logic [COLOR_BITS-1:0] vga_r_d, vga_g_d, vga_b_d;
  logic [COLOR_BITS-1:0] vga_r_q, vga_g_q, vga_b_q;

  always_comb begin
    vga_r_d = OFF;
    vga_g_d = OFF;
    vga_b_d = OFF;
    if (active_q) begin
      if (player_hit_q) begin
        vga_g_d = FULL;
      end else if (car_hit_q) begin
        vga_r_d = FULL;
      end else if (tile_hit_q) begin
        vga_r_d = FULL;
        vga_g_d = FULL;
        vga_b_d = FULL;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      player_hit_q <= 1'b0;
      car_hit_q    <= 1'b0;
      tile_hit_q   <= 1'b0;
      active_q     <= 1'b0;
      col_phase_q  <= '0;
      col_idx_q    <= '0;
      col_vld_q    <= 1'b0;
      row_phase_q  <= '0;
      row_idx_q    <= '0;
      row_vld_q    <= 1'b0;
      vga_r_q      <= '0;
      vga_g_q      <= '0;
      vga_b_q      <= '0;
    end else begin
      player_hit_q <= player_hit_d;
      car_hit_q    <= car_hit_d;
      tile_hit_q   <= tile_hit_d;
      active_q     <= active_d;
      col_phase_q  <= col_phase_d;
      col_idx_q    <= col_idx_d;
      col_vld_q    <= col_vld_d;
      row_phase_q  <= row_phase_d;
      row_idx_q    <= row_idx_d;
      row_vld_q    <= row_vld_d;
      vga_r_q      <= vga_r_d;
      vga_g_q      <= vga_g_d;
      vga_b_q      <= vga_b_d;
    end
  end

  assign VGA_R = vga_r_q;
  assign VGA_G = vga_g_q;
  assign VGA_B = vga_b_q;

`ifdef SCENE_COLLISION_EN
  // A hit registered on the same edge as the frame-end sample still counts for the closing frame.
  logic       frame_end, hit_now;
  logic       sticky_d, sticky_q;
  logic       coll_d, coll_q;
  logic [7:0] count_d, count_q;

  assign frame_end = (h_count == 10'd0) && (v_count == 10'(V_DISPLAY));
  assign hit_now   = active_q && player_hit_q && car_hit_q;

  always_comb begin
    sticky_d = sticky_q | hit_now;
    coll_d   = 1'b0;
    count_d  = count_q;
    if (frame_end) begin
      sticky_d = 1'b0;
      coll_d   = sticky_q | hit_now;
      if ((sticky_q | hit_now) && (count_q != 8'hFF)) count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sticky_q <= 1'b0;
      coll_q   <= 1'b0;
      count_q  <= 8'd0;
    end else begin
      sticky_q <= sticky_d;
      coll_q   <= coll_d;
      count_q  <= count_d;
    end
  end

  assign collision       = coll_q;
  assign collision_count = count_q;
`else
  assign collision       = 1'b0;
  assign collision_count = 8'd0;
`endif

endmodule

// File: tb/tb_scene_renderer.sv
// Bench for scene_renderer: directed scene checks plus randomized raster sweeps against a
// cycle-counting arithmetic reference model (collision expectations follow SCENE_COLLISION_EN).
module tb_scene_renderer;

  localparam int NC = 4, CB = 1;
  localparam int HD = 640, VD = 480;
  localparam int PW = 16, PH = 16, CW = 32, CH = 16;
  localparam int TX0 = 10, TY0 = 320, TPX = 35, TPY = 32, TW = 30, TH = 28, TCOLS = 18, TROWS = 5;

  localparam logic [CB-1:0] FULL = '1;
  localparam logic [CB-1:0] ZERO = '0;
  localparam logic [3*CB-1:0] BLACK = {ZERO, ZERO, ZERO};
  localparam logic [3*CB-1:0] GREEN = {ZERO, FULL, ZERO};
  localparam logic [3*CB-1:0] RED   = {FULL, ZERO, ZERO};
  localparam logic [3*CB-1:0] WHITE = {FULL, FULL, FULL};

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [9:0] h_count = '0, v_count = '0, player_x = '0, player_y = '0;
  logic [10*NC-1:0] car_x = '0, car_y = '0;
  logic [CB-1:0] vga_r, vga_g, vga_b;
  logic collision;
  logic [7:0] collision_count;

  always #5 clk = ~clk;

  scene_renderer #(.NUM_CARS(NC), .COLOR_BITS(CB)) dut (
    .CLK(clk), .RST_N(rst_n), .h_count(h_count), .v_count(v_count),
    .player_x(player_x), .player_y(player_y), .car_x(car_x), .car_y(car_y),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .collision(collision), .collision_count(collision_count)
  );

  // Scene and reference-model state
  int px, py;
  int cx[NC];
  int cy[NC];
  int cpos, rpos;
  bit cvalid, rvalid, frame_hit, exp_coll;
  int exp_cnt;
  logic [3*CB-1:0] exp_q[$];
  int n_cmp = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit in_box(int h, int v, int x, int y, int w, int hh);
    return (h >= x) && (h < x + w) && (v >= y) && (v < y + hh);
  endfunction

  function automatic logic [3*CB-1:0] model_colour(int h, int v, bit ph, bit ch);
    bit tile;
    tile = cvalid && rvalid && (cpos / TPX < TCOLS) && (cpos % TPX < TW) &&
           (rpos / TPY < TROWS) && (rpos % TPY < TH);
    if (!(h < HD && v < VD)) return BLACK;
    if (ph) return GREEN;
    if (ch) return RED;
    if (tile) return WHITE;
    return BLACK;
  endfunction

  function automatic logic [3*CB-1:0] rgb();
    return {vga_r, vga_g, vga_b};
  endfunction

  task automatic step(input int h, input int v);
    bit ph, ch;
    @(negedge clk);
    h_count  = 10'(h);
    v_count  = 10'(v);
    player_x = 10'(px);
    player_y = 10'(py);
    for (int i = 0; i < NC; i++) begin
      car_x[10*i +: 10] = 10'(cx[i]);
      car_y[10*i +: 10] = 10'(cy[i]);
    end
    // tile position = cycles since the column origin, lines since the row origin
    if (h == TX0) begin cpos = 0; cvalid = 1; end
    else if (cvalid) cpos++;
    if (h == 0) begin
      if (v == TY0) begin rpos = 0; rvalid = 1; end
      else if (rvalid) rpos++;
    end
    ph = in_box(h, v, px, py, PW, PH);
    ch = 0;
    for (int i = 0; i < NC; i++) ch |= in_box(h, v, cx[i], cy[i], CW, CH);
    exp_q.push_back(model_colour(h, v, ph, ch));
    exp_coll = 0;
`ifdef SCENE_COLLISION_EN
    if (h == 0 && v == VD) begin
      exp_coll  = frame_hit;
      frame_hit = 0;
      if (exp_coll && exp_cnt < 255) exp_cnt++;
    end
    if (h < HD && v < VD && ph && ch) frame_hit = 1;
`endif
    @(posedge clk);
    #1;
    check("rgb", 32'(rgb()), 32'(exp_q.pop_front()));
    check("collision", 32'(collision), 32'(exp_coll));
    check("coll_count", 32'(collision_count), 32'(exp_cnt));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_rgb", 32'(rgb()), 32'(BLACK));
    check("rst_collision", 32'(collision), 32'd0);
    check("rst_coll_count", 32'(collision_count), 32'd0);
    exp_q.delete();
    exp_q.push_back(BLACK);
    cvalid = 0; rvalid = 0; cpos = 0; rpos = 0;
    frame_hit = 0; exp_cnt = 0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic park_cars();
    for (int i = 0; i < NC; i++) begin cx[i] = 700 + 40 * i; cy[i] = 700; end
  endtask

  initial begin
    px = 900; py = 900;
    park_cars();
    #3;
    do_reset();

    // player pixel -> green
    px = 100; py = 100;
    step(105, 105);
    step(106, 105);
    check("player_green", 32'(rgb()), 32'(GREEN));

    // sprites outside the active area -> black
    px = 645; py = 100;
    step(650, 100);
    step(651, 100);
    check("inactive_h_black", 32'(rgb()), 32'(BLACK));
    px = 900; py = 900;
    cx[0] = 100; cy[0] = 485;
    step(105, 490);
    step(106, 490);
    check("inactive_v_black", 32'(rgb()), 32'(BLACK));

    // tiles: first tile white, first gap black, car over tile red
    px = 500; py = 50;
    cx[0] = 200; cy[0] = 350;
    for (int h = 0; h <= 60; h++) begin
      step(h, 320);
      if (h == 11) check("tile_white", 32'(rgb()), 32'(WHITE));
      if (h == 41) check("tile_gap_black", 32'(rgb()), 32'(BLACK));
    end
    for (int v = 321; v < 355; v++) step(0, v);
    for (int h = 0; h <= 220; h++) begin
      step(h, 355);
      if (h == 211) check("car_over_tile_red", 32'(rgb()), 32'(RED));
    end

    // collision frame, then a clean frame
    px = 300; py = 200;
    cx[1] = 300; cy[1] = 200;
    step(0, VD);
    step(305, 205);
    step(0, VD);
`ifdef SCENE_COLLISION_EN
    check("coll_pulse", 32'(collision), 32'd1);
    check("coll_count_1", 32'(collision_count), 32'd1);
`endif
    cx[1] = 600;
    step(305, 205);
    step(0, VD);
    check("coll_quiet_frame", 32'(collision), 32'd0);

    // long overlap saturates the counter
    cx[1] = 300;
    repeat (300) begin
      step(305, 205);
      step(0, VD);
    end
`ifdef SCENE_COLLISION_EN
    check("coll_count_sat", 32'(collision_count), 32'd255);
`else
    check("coll_count_tied", 32'(collision_count), 32'd0);
`endif

    // asynchronous reset mid-frame with the sticky flag set
    step(305, 205);
    step(306, 205);
    check("pre_reset_green", 32'(rgb()), 32'(GREEN));
    #2;
    do_reset();
    cx[1] = 600;
    step(0, VD);
    check("no_pulse_after_reset", 32'(collision), 32'd0);

    // randomized raster sweeps with moving sprites
    for (int f = 0; f < 4; f++) begin
      px = $urandom_range(0, 700);
      py = $urandom_range(280, 500);
      for (int i = 0; i < NC; i++) begin
        cx[i] = $urandom_range(0, 700);
        cy[i] = $urandom_range(280, 500);
      end
      if ($urandom_range(0, 1) == 1) begin
        int k;
        k = $urandom_range(0, NC - 1);
        cx[k] = px + $urandom_range(0, 8);
        cy[k] = py + $urandom_range(0, 8);
      end
      for (int v = 300; v <= 490; v++) begin
        step(0, v);
        if ($urandom_range(0, 9) == 0) begin
          int len;
          len = $urandom_range(50, 700);
          for (int h = 1; h <= len; h++) begin
            if ($urandom_range(0, 199) == 0) px = (px + 1) % 1024;
            step(h, v);
          end
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
